// File: rtl/lfsr_seq_checker.sv
// lfsr_seq_checker
//   Receive-side checker for a 4-bit LFSR stream (x^4+x^3+1, period 15).
//   A local model of the LFSR self-synchronises to the incoming samples.
//   Once CONFIRM_N consecutive predictions have been correct it declares
//   lock. While locked it counts matching and mismatching samples.
//
// Ports
//   i_clk        system clock
//   i_rst        synchronous active-high reset
//   i_start      level enable; low forces IDLE, counters hold
//   i_clear      one-cycle pulse; zeroes counters, returns to IDLE
//   i_valid      i_data carries a new sample this cycle
//   i_data       received 4-bit sample
//   o_state      IDLE=0, ACQUIRE=1, LOCKED=2, LOST=3
//   o_locked     high only in LOCKED
//   o_expected   predicted value of the next sample
//   o_match_cnt  saturating count of correct samples while LOCKED
//   o_err_cnt    saturating count of mispredicted samples while LOCKED
//
// state   | meaning
// IDLE    | waiting for a first non-zero sample to seed the model
// ACQUIRE | model seeded, collecting consecutive correct predictions
// LOCKED  | model free-runs (flywheel), samples are scored
// LOST    | too many consecutive misses; next non-zero sample reseeds
module lfsr_seq_checker #(
  parameter int CONFIRM_N = 3,
  parameter int LOSS_N    = 4,
  parameter int CNT_W     = 16
) (
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic             i_start,
  input  logic             i_clear,
  input  logic             i_valid,
  input  logic [3:0]       i_data,
  output logic [1:0]       o_state,
  output logic             o_locked,
  output logic [3:0]       o_expected,
  output logic [CNT_W-1:0] o_match_cnt,
  output logic [CNT_W-1:0] o_err_cnt
);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    ACQUIRE = 2'd1,
    LOCKED  = 2'd2,
    LOST    = 2'd3
  } state_t;

  state_t           r_state;
  logic             r_locked;
  logic [3:0]       r_expected;
  logic [CNT_W-1:0] r_match_cnt;
  logic [CNT_W-1:0] r_err_cnt;
  logic [7:0]       r_conf;
  logic [7:0]       r_loss;

  logic             w_match;
  logic             w_nonzero;

  function automatic logic [3:0] nxt(input logic [3:0] q);
    return {q[2:0], q[3] ^ q[2]};
  endfunction

  assign w_match   = (i_data == r_expected);
  assign w_nonzero = (i_data != 4'h0);

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_state     <= IDLE;
      r_locked    <= 1'b0;
      r_expected  <= 4'h0;
      r_match_cnt <= '0;
      r_err_cnt   <= '0;
      r_conf      <= 8'd0;
      r_loss      <= 8'd0;
    end else if (i_clear) begin
      r_state     <= IDLE;
      r_locked    <= 1'b0;
      r_expected  <= 4'h0;
      r_match_cnt <= '0;
      r_err_cnt   <= '0;
      r_conf      <= 8'd0;
      r_loss      <= 8'd0;
    end else if (!i_start) begin
      r_state  <= IDLE;
      r_locked <= 1'b0;
      r_conf   <= 8'd0;
      r_loss   <= 8'd0;
    end else if (i_valid) begin
      case (r_state)
        IDLE, LOST: begin
          // zero can never come out of the LFSR, so it cannot seed the model
          if (w_nonzero) begin
            r_expected <= nxt(i_data);
            r_conf     <= 8'd0;
            r_state    <= ACQUIRE;
          end
        end
        ACQUIRE: begin
          if (w_match) begin
            r_expected <= nxt(i_data);
            if (r_conf + 8'd1 == 8'(CONFIRM_N)) begin
              r_state  <= LOCKED;
              r_locked <= 1'b1;
              r_conf   <= 8'd0;
              r_loss   <= 8'd0;
            end else begin
              r_conf <= r_conf + 8'd1;
            end
          end else if (w_nonzero) begin
            r_expected <= nxt(i_data);
            r_conf     <= 8'd0;
          end else begin
            r_conf <= 8'd0;
          end
        end
        LOCKED: begin
          // flywheel: the prediction advances on its own, so a corrupted
          // sample cannot drag the model off the sequence
          r_expected <= nxt(r_expected);
          if (w_match) begin
            if (r_match_cnt != '1) r_match_cnt <= r_match_cnt + 1'b1;
            r_loss <= 8'd0;
          end else begin
            if (r_err_cnt != '1) r_err_cnt <= r_err_cnt + 1'b1;
            if (r_loss + 8'd1 == 8'(LOSS_N)) begin
              r_state  <= LOST;
              r_locked <= 1'b0;
              r_loss   <= 8'd0;
            end else begin
              r_loss <= r_loss + 8'd1;
            end
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  assign o_state     = r_state;
  assign o_locked    = r_locked;
  assign o_expected  = r_expected;
  assign o_match_cnt = r_match_cnt;
  assign o_err_cnt   = r_err_cnt;

endmodule
